r_reorder_unit: RTL and testbench

- Restores issue order for AXI read responses. Each read is assigned a tag when it is issued; slave R beats can return in any tag order.
- Beats are stored per tag and released in tag-allocation order, with the original AXI ID restored.
- Sits between the slave-side R channel and the outgoing R response FIFO, and feeds that FIFO's R input.

---
 rtl/rob_pkg.sv | 32 +++
 rtl/r_if.sv | 16 +
 rtl/r_rob_slot.sv | 91 +++++++++
 rtl/r_reorder_unit.sv | 121 ++++++++++++
 tb/tb_r_reorder_unit.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rob_pkg.sv
// Shared types and helpers for the AXI read reorder unit.
package rob_pkg;

    localparam int ID_W_DEF      = 32;
    localparam int DATA_W_DEF    = 64;
    localparam int RESP_W_DEF    = 2;
    localparam int NUM_TAGS_DEF  = 8;
    localparam int MAX_BEATS_DEF = 4;

    localparam int TAG_W  = $clog2(NUM_TAGS_DEF);
    localparam int BCNT_W = $clog2(MAX_BEATS_DEF + 1);

    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic [RESP_W_DEF-1:0] resp;
        logic                  last;
    } r_beat_t;

    typedef struct packed {
        logic                alloc;
        logic                done;
        logic [BCNT_W-1:0]   wr_cnt;
        logic [BCNT_W-1:0]   rd_cnt;
        logic [ID_W_DEF-1:0] orig_id;
    } slot_rec_t;

    // Index width for an array of n entries; a one-entry array still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/r_if.sv
// AXI R channel bundle: valid/ready handshake plus id, data, resp and last.
interface r_if #(
    parameter int ID_WIDTH   = 32,
    parameter int DATA_WIDTH = 64,
    parameter int RESP_WIDTH = 2
);
    logic                  valid;
    logic                  ready;
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [RESP_WIDTH-1:0] resp;
    logic                  last;

    modport sender   (output valid, id, data, resp, last, input ready);
    modport receiver (input valid, id, data, resp, last, output ready);
endinterface

// File: rtl/r_rob_slot.sv
// One reorder slot: holds the original ID and up to MAX_BEATS stored R beats
// for a single outstanding read, with separate write and read counters.
module r_rob_slot
    import rob_pkg::*;
#(
    parameter int ID_WIDTH   = 32,
    parameter int DATA_WIDTH = 64,
    parameter int RESP_WIDTH = 2,
    parameter int MAX_BEATS  = 4,
    localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_stb,
    input  logic [ID_WIDTH-1:0]   alloc_id,
    input  logic                  wr_stb,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [RESP_WIDTH-1:0] wr_resp,
    input  logic                  wr_last,
    input  logic                  pop_stb,
    output logic                  alloc,
    output logic                  done,
    output logic [CNT_W-1:0]      wr_cnt,
    output logic [CNT_W-1:0]      rd_cnt,
    output logic [ID_WIDTH-1:0]   orig_id,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [RESP_WIDTH-1:0] rd_resp,
    output logic                  rd_last
);

    localparam int IDX_W = idx_w(MAX_BEATS);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [RESP_WIDTH-1:0] resp;
        logic                  last;
    } beat_t;

    beat_t            beats [MAX_BEATS];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             forced_last;

    // The final storable beat is always marked last so the slot can never overfill.
    assign forced_last = wr_last | (wr_cnt == CNT_W'(MAX_BEATS - 1));
    assign wr_idx      = wr_cnt[IDX_W-1:0];
    assign rd_idx      = rd_cnt[IDX_W-1:0];
    assign rd_data     = beats[rd_idx].data;
    assign rd_resp     = beats[rd_idx].resp;
    assign rd_last     = beats[rd_idx].last;

    // Slot bookkeeping: allocation resets the slot, writes and pops may coincide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alloc   <= 1'b0;
            done    <= 1'b0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            orig_id <= '0;
        end else if (alloc_stb) begin
            alloc   <= 1'b1;
            done    <= 1'b0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            orig_id <= alloc_id;
        end else begin
            if (wr_stb) begin
                wr_cnt <= wr_cnt + CNT_W'(1);
                if (forced_last) begin
                    done <= 1'b1;
                end
            end
            if (pop_stb) begin
                if (rd_last) begin
                    alloc  <= 1'b0;
                    rd_cnt <= '0;
                end else begin
                    rd_cnt <= rd_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Beat payload storage; validity is tracked by the counters, so no reset is needed.
    always_ff @(posedge clk) begin
        if (wr_stb) begin
            beats[wr_idx] <= '{data: wr_data, resp: wr_resp, last: forced_last};
        end
    end

endmodule

// File: rtl/r_reorder_unit.sv
// AXI read reorder unit: tags reads at issue, buffers R beats per tag and
// releases them in tag-allocation order with the original ARID restored.
module r_reorder_unit
    import rob_pkg::*;
#(
    parameter int ID_WIDTH   = 32,
    parameter int DATA_WIDTH = 64,
    parameter int RESP_WIDTH = 2,
    parameter int NUM_TAGS   = 8,
    parameter int MAX_BEATS  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        alloc_valid,
    output logic                        alloc_ready,
    input  logic [ID_WIDTH-1:0]         alloc_id,
    output logic [$clog2(NUM_TAGS)-1:0] alloc_tag,
    r_if.receiver                       r_in,
    r_if.sender                         r_out,
    output logic                        err
);

    localparam int TW = $clog2(NUM_TAGS);
    localparam int CW = $clog2(MAX_BEATS + 1);

    logic [TW-1:0]         head;
    logic [TW-1:0]         tail;
    logic [NUM_TAGS-1:0]   slot_alloc;
    logic [NUM_TAGS-1:0]   slot_done;
    logic [NUM_TAGS-1:0]   slot_rd_last;
    logic [NUM_TAGS-1:0]   alloc_stb;
    logic [NUM_TAGS-1:0]   wr_stb;
    logic [NUM_TAGS-1:0]   pop_stb;
    logic [CW-1:0]         slot_wr_cnt  [NUM_TAGS];
    logic [CW-1:0]         slot_rd_cnt  [NUM_TAGS];
    logic [ID_WIDTH-1:0]   slot_id      [NUM_TAGS];
    logic [DATA_WIDTH-1:0] slot_rd_data [NUM_TAGS];
    logic [RESP_WIDTH-1:0] slot_rd_resp [NUM_TAGS];

    logic [TW-1:0] in_tag;
    logic          in_fire;
    logic          in_ok;
    logic          in_ovf;
    logic          alloc_fire;
    logic          out_valid;
    logic          pop_fire;

    assign in_tag      = r_in.id[TW-1:0];
    assign in_fire     = rst & r_in.valid;
    assign in_ok       = slot_alloc[in_tag] & ~slot_done[in_tag];
    assign in_ovf      = (slot_wr_cnt[in_tag] == CW'(MAX_BEATS - 1)) & ~r_in.last;
    assign r_in.ready  = rst;

    assign alloc_ready = rst & ~slot_alloc[tail];
    assign alloc_fire  = alloc_valid & alloc_ready;
    assign alloc_tag   = tail;

    assign out_valid   = rst & slot_alloc[head] & (slot_rd_cnt[head] < slot_wr_cnt[head]);
    assign pop_fire    = out_valid & r_out.ready;

    assign r_out.valid = out_valid;
    assign r_out.id    = out_valid ? slot_id[head]      : '0;
    assign r_out.data  = out_valid ? slot_rd_data[head] : '0;
    assign r_out.resp  = out_valid ? slot_rd_resp[head] : '0;
    assign r_out.last  = out_valid ? slot_rd_last[head] : 1'b0;

    // Steer alloc, write and pop strobes to the tail, tagged and head slots.
    always_comb begin
        alloc_stb = '0;
        wr_stb    = '0;
        pop_stb   = '0;
        alloc_stb[tail]  = alloc_fire;
        wr_stb[in_tag]   = in_fire & in_ok;
        pop_stb[head]    = pop_fire;
    end

    // Head/tail pointers wrap naturally; err flags dropped or truncated beats.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            err  <= 1'b0;
        end else begin
            if (alloc_fire) begin
                tail <= tail + TW'(1);
            end
            if (pop_fire && slot_rd_last[head]) begin
                head <= head + TW'(1);
            end
            err <= in_fire & (~in_ok | in_ovf);
        end
    end

    for (genvar g = 0; g < NUM_TAGS; g++) begin : g_slot
        r_rob_slot #(
            .ID_WIDTH   (ID_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .RESP_WIDTH (RESP_WIDTH),
            .MAX_BEATS  (MAX_BEATS)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .alloc_stb (alloc_stb[g]),
            .alloc_id  (alloc_id),
            .wr_stb    (wr_stb[g]),
            .wr_data   (r_in.data),
            .wr_resp   (r_in.resp),
            .wr_last   (r_in.last),
            .pop_stb   (pop_stb[g]),
            .alloc     (slot_alloc[g]),
            .done      (slot_done[g]),
            .wr_cnt    (slot_wr_cnt[g]),
            .rd_cnt    (slot_rd_cnt[g]),
            .orig_id   (slot_id[g]),
            .rd_data   (slot_rd_data[g]),
            .rd_resp   (slot_rd_resp[g]),
            .rd_last   (slot_rd_last[g])
        );
    end

endmodule

// File: tb/tb_r_reorder_unit.sv
// Scoreboard bench for r_reorder_unit: directed stimulus pushes expected
// reordered beats, an independent monitor pops and compares each output.
module tb_r_reorder_unit;
    import rob_pkg::*;

    localparam int ID_W   = 32;
    localparam int DATA_W = 64;
    localparam int RESP_W = 2;

    typedef struct packed {
        logic [ID_W-1:0] id;
        r_beat_t         beat;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            alloc_valid = 1'b0;
    logic [ID_W-1:0] alloc_id = '0;
    logic            alloc_ready;
    logic [2:0]      alloc_tag;
    logic            err;

    r_if #(.ID_WIDTH(ID_W), .DATA_WIDTH(DATA_W), .RESP_WIDTH(RESP_W)) rin ();
    r_if #(.ID_WIDTH(ID_W), .DATA_WIDTH(DATA_W), .RESP_WIDTH(RESP_W)) rout ();

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    r_reorder_unit #(
        .ID_WIDTH   (ID_W),
        .DATA_WIDTH (DATA_W),
        .RESP_WIDTH (RESP_W),
        .NUM_TAGS   (8),
        .MAX_BEATS  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alloc_valid (alloc_valid),
        .alloc_ready (alloc_ready),
        .alloc_id    (alloc_id),
        .alloc_tag   (alloc_tag),
        .r_in        (rin),
        .r_out       (rout),
        .err         (err)
    );

    // Compare one observed value against its expected value and tally the result.
    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] id, input logic [63:0] data, input logic [1:0] resp, input logic last);
        exp_t e;
        e.id        = id;
        e.beat.data = data;
        e.beat.resp = resp;
        e.beat.last = last;
        exp_q.push_back(e);
    endtask

    task automatic apply_alloc(input logic [31:0] id, input logic [2:0] exp_tag);
        check_output("alloc_ready", 128'(alloc_ready), 128'(1));
        check_output("alloc_tag", 128'(alloc_tag), 128'(exp_tag));
        alloc_valid = 1'b1;
        alloc_id    = id;
        step();
        alloc_valid = 1'b0;
    endtask

    task automatic apply_beat(input logic [2:0] tag, input logic [63:0] data, input logic [1:0] resp,
                              input logic last, input logic exp_err);
        rin.valid = 1'b1;
        rin.id    = {29'h1ABCDE0, tag};
        rin.data  = data;
        rin.resp  = resp;
        rin.last  = last;
        step();
        rin.valid = 1'b0;
        rin.last  = 1'b0;
        check_output("err", 128'(err), 128'(exp_err));
    endtask

    // Monitor: every completed output handshake must match the next expected beat.
    always @(negedge clk) begin
        if (rst && rout.valid && rout.ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_beat got id=%h data=%h last=%b expected none", rout.id, rout.data, rout.last);
            end else begin
                mon_e = exp_q.pop_front();
                check_output("r_out_beat", 128'({rout.id, rout.data, rout.resp, rout.last}), 128'(mon_e));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] held_id;
        logic [63:0] held_data;
        int          waited;

        rin.valid  = 1'b0;
        rin.id     = '0;
        rin.data   = '0;
        rin.resp   = '0;
        rin.last   = 1'b0;
        rout.ready = 1'b1;

        // Reset held for three cycles
        repeat (3) begin
            @(negedge clk);
            check_output("rst_alloc_ready", 128'(alloc_ready), 128'(0));
            check_output("rst_out_valid", 128'(rout.valid), 128'(0));
            check_output("rst_err", 128'(err), 128'(0));
            check_output("rst_in_ready", 128'(rin.ready), 128'(0));
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_output("post_rst_alloc_ready", 128'(alloc_ready), 128'(1));
        check_output("post_rst_alloc_tag", 128'(alloc_tag), 128'(0));
        check_output("post_rst_in_ready", 128'(rin.ready), 128'(1));

        // Reversed single-beat completion order
        apply_alloc(32'hA, 3'd0);
        apply_alloc(32'hB, 3'd1);
        apply_alloc(32'hC, 3'd2);
        push_exp(32'hA, 64'h1111, 2'b00, 1'b1);
        push_exp(32'hB, 64'h2222, 2'b10, 1'b1);
        push_exp(32'hC, 64'h3333, 2'b00, 1'b1);
        apply_beat(3'd2, 64'h3333, 2'b00, 1'b1, 1'b0);
        check_output("head_wait_2", 128'(rout.valid), 128'(0));
        apply_beat(3'd1, 64'h2222, 2'b10, 1'b1, 1'b0);
        check_output("head_wait_1", 128'(rout.valid), 128'(0));
        apply_beat(3'd0, 64'h1111, 2'b00, 1'b1, 1'b0);
        check_output("first_beat_valid", 128'(rout.valid), 128'(1));
        check_output("first_beat_id", 128'(rout.id), 128'(32'hA));
        repeat (3) step();
        check_output("reverse_drained", 128'(rout.valid), 128'(0));

        // Cut-through burst of four beats
        apply_alloc(32'h5, 3'd3);
        for (int i = 1; i <= 4; i++) begin
            push_exp(32'h5, 64'(i), 2'b00, (i == 4));
        end
        for (int i = 1; i <= 4; i++) begin
            apply_beat(3'd3, 64'(i), 2'b00, (i == 4), 1'b0);
            check_output("cut_valid", 128'(rout.valid), 128'(1));
            check_output("cut_data", 128'(rout.data), 128'(i));
        end
        step();
        check_output("cut_done_valid", 128'(rout.valid), 128'(0));

        // Beat to a freed slot is dropped with a single-cycle err
        apply_beat(3'd3, 64'hBAD, 2'b00, 1'b1, 1'b1);
        check_output("drop_no_output", 128'(rout.valid), 128'(0));
        step();
        check_output("err_pulse_width", 128'(err), 128'(0));

        // Four beats without last: fourth is truncated to last with err
        apply_alloc(32'h77, 3'd4);
        for (int i = 1; i <= 4; i++) begin
            push_exp(32'h77, 64'h700 + 64'(i), 2'b01, (i == 4));
        end
        for (int i = 1; i <= 4; i++) begin
            apply_beat(3'd4, 64'h700 + 64'(i), 2'b01, 1'b0, (i == 4));
        end
        step();
        check_output("ovf_done_valid", 128'(rout.valid), 128'(0));

        // Backpressure: payload held steady while ready is low
        rout.ready = 1'b0;
        apply_alloc(32'h99, 3'd5);
        push_exp(32'h99, 64'hDEAD_BEEF, 2'b11, 1'b1);
        apply_beat(3'd5, 64'hDEAD_BEEF, 2'b11, 1'b1, 1'b0);
        held_id   = rout.id;
        held_data = rout.data;
        repeat (5) begin
            check_output("bp_valid", 128'(rout.valid), 128'(1));
            check_output("bp_id", 128'(rout.id), 128'(32'h99));
            check_output("bp_data_stable", 128'(rout.data), 128'(held_data));
            check_output("bp_id_stable", 128'(rout.id), 128'(held_id));
            step();
        end
        rout.ready = 1'b1;
        step();
        check_output("bp_single_pop", 128'(rout.valid), 128'(0));

        // Reset in the middle of operation discards stored beats
        rout.ready = 1'b0;
        apply_alloc(32'h66, 3'd6);
        apply_beat(3'd6, 64'h66, 2'b00, 1'b1, 1'b0);
        check_output("pre_rst_valid", 128'(rout.valid), 128'(1));
        rst = 1'b0;
        #2;
        check_output("mid_rst_valid", 128'(rout.valid), 128'(0));
        check_output("mid_rst_alloc_ready", 128'(alloc_ready), 128'(0));
        step();
        step();
        rst = 1'b1;
        rout.ready = 1'b1;
        #1;
        check_output("re_rst_alloc_tag", 128'(alloc_tag), 128'(0));
        check_output("re_rst_valid", 128'(rout.valid), 128'(0));

        // Fill all eight tags, then free tag 0 and wrap
        for (int i = 0; i < 8; i++) begin
            apply_alloc(32'h100 + 32'(i), 3'(i));
        end
        check_output("full_alloc_ready", 128'(alloc_ready), 128'(0));
        check_output("full_alloc_tag", 128'(alloc_tag), 128'(0));
        push_exp(32'h100, 64'hF00D, 2'b00, 1'b1);
        apply_beat(3'd0, 64'hF00D, 2'b00, 1'b1, 1'b0);
        check_output("full_before_pop", 128'(alloc_ready), 128'(0));
        step();
        check_output("wrap_alloc_ready", 128'(alloc_ready), 128'(1));
        check_output("wrap_alloc_tag", 128'(alloc_tag), 128'(0));

        // Allocate tag 0 and send a beat for tag 0 in the same cycle
        alloc_valid = 1'b1;
        alloc_id    = 32'h200;
        rin.valid   = 1'b1;
        rin.id      = 32'h0;
        rin.data    = 64'h5A5A;
        rin.resp    = 2'b00;
        rin.last    = 1'b1;
        step();
        alloc_valid = 1'b0;
        rin.valid   = 1'b0;
        rin.last    = 1'b0;
        check_output("same_cycle_err", 128'(err), 128'(1));
        check_output("same_cycle_tag", 128'(alloc_tag), 128'(1));
        check_output("same_cycle_no_out", 128'(rout.valid), 128'(0));
        check_output("same_cycle_full", 128'(alloc_ready), 128'(0));

        // Drain: every expected beat must have been seen within a bounded wait
        waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            step();
            waited++;
        end
        check_output("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
